// File: rtl/puf_meas_ctrl_if.sv
// Handshake and data bundle between the PUF measurement sequencer,
// the window counter / RO mux and the response host.
interface puf_meas_ctrl_if #(
    parameter int RESP_BITS = 8,
    parameter int CHAL_W    = 3,
    parameter int OSC_W     = 16
);

    logic                 i_start;
    logic                 i_cnt_valid;
    logic [OSC_W-1:0]     i_osc_a;
    logic [OSC_W-1:0]     i_osc_b;
    logic                 i_resp_ack;

    logic                 o_cnt_en;
    logic                 o_osc_clr;
    logic [CHAL_W-1:0]    o_chal;
    logic [RESP_BITS-1:0] o_resp;
    logic                 o_resp_valid;
    logic                 o_busy;
    logic                 o_err;

    modport master (
        output i_start,
        output i_cnt_valid,
        output i_osc_a,
        output i_osc_b,
        output i_resp_ack,
        input  o_cnt_en,
        input  o_osc_clr,
        input  o_chal,
        input  o_resp,
        input  o_resp_valid,
        input  o_busy,
        input  o_err
    );

    modport slave (
        input  i_start,
        input  i_cnt_valid,
        input  i_osc_a,
        input  i_osc_b,
        input  i_resp_ack,
        output o_cnt_en,
        output o_osc_clr,
        output o_chal,
        output o_resp,
        output o_resp_valid,
        output o_busy,
        output o_err
    );

endinterface

// File: rtl/puf_meas_ctrl.sv
// Ring-oscillator PUF measurement sequencer: one window per challenge,
// compares frozen edge counts and assembles the response word.
module puf_meas_ctrl #(
    parameter int RESP_BITS = 8,
    parameter int CHAL_W    = 3,
    parameter int OSC_W     = 16,
    parameter int TIMEOUT   = 63,
    parameter int TO_W      = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    puf_meas_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MEASURE,
        S_EVAL,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [TO_W-1:0]      to_cnt;
    logic [CHAL_W-1:0]    chal_q;
    logic [RESP_BITS-1:0] resp_q;
    logic                 cnt_en_q;
    logic                 osc_clr_q;
    logic                 resp_valid_q;
    logic                 busy_q;
    logic                 err_q;

    logic [OSC_W-1:0]     osc_a;
    logic [OSC_W-1:0]     osc_b;

    logic to_hit;
    logic chal_last;
    logic start_run;
    logic timed_out;
    logic bit_val;

    assign osc_a = bus.i_osc_a;
    assign osc_b = bus.i_osc_b;

    assign to_hit    = (to_cnt == TO_W'(TIMEOUT - 1));
    assign chal_last = (chal_q == CHAL_W'(RESP_BITS - 1));
    assign bit_val   = (osc_a > osc_b);

    always_comb begin
        state_nxt = state;
        start_run = 1'b0;
        timed_out = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.i_start) begin
                    start_run = 1'b1;
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_nxt = S_MEASURE;
            end
            S_MEASURE: begin
                // a window completing on the timeout cycle still counts
                if (bus.i_cnt_valid) begin
                    state_nxt = S_EVAL;
                end else if (to_hit) begin
                    timed_out = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_EVAL: begin
                state_nxt = S_NEXT;
            end
            S_NEXT: begin
                state_nxt = chal_last ? S_DONE : S_CLEAR;
            end
            S_DONE: begin
                if (bus.i_resp_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt_en_q     <= 1'b0;
            osc_clr_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt_en_q     <= (state_nxt == S_MEASURE);
            osc_clr_q    <= (state_nxt == S_CLEAR);
            resp_valid_q <= (state_nxt == S_DONE);
            busy_q       <= (state_nxt != S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == S_CLEAR) begin
            to_cnt <= '0;
        end else if (state == S_MEASURE) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chal_q <= '0;
        end else if (start_run) begin
            chal_q <= '0;
        end else if (state == S_NEXT && !chal_last) begin
            chal_q <= chal_q + 1'b1;
        end
    end

    // counts are frozen here since the enable dropped entering EVAL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q <= '0;
        end else if (start_run) begin
            resp_q <= '0;
        end else if (state == S_EVAL) begin
            resp_q[chal_q] <= bit_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (start_run) begin
            err_q <= 1'b0;
        end else if (timed_out) begin
            err_q <= 1'b1;
        end
    end

    assign bus.o_cnt_en     = cnt_en_q;
    assign bus.o_osc_clr    = osc_clr_q;
    assign bus.o_chal       = chal_q;
    assign bus.o_resp       = resp_q;
    assign bus.o_resp_valid = resp_valid_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_err        = err_q;

`ifndef SYNTHESIS
    a_chal_range: assert property (
        @(posedge clk) disable iff (!rst_n)
        chal_q <= CHAL_W'(RESP_BITS - 1)
    );

    a_done_hold: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state == S_DONE && !bus.i_resp_ack)
        |=> ($stable(resp_q) && resp_valid_q)
    );

    a_en_busy: assert property (
        @(posedge clk) disable iff (!rst_n)
        cnt_en_q |-> busy_q
    );
`endif

endmodule

// File: tb/tb_puf_meas_ctrl.sv
// Randomized bench for puf_meas_ctrl with a window-counter model
// and a per-challenge compare reference.
module tb_puf_meas_ctrl;

    localparam int RB  = 8;
    localparam int TMO = 63;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    puf_meas_ctrl_if #(
        .RESP_BITS(RB),
        .CHAL_W(3),
        .OSC_W(16)
    ) bus ();

    puf_meas_ctrl #(
        .RESP_BITS(RB),
        .CHAL_W(3),
        .OSC_W(16),
        .TIMEOUT(TMO),
        .TO_W(6)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    int win_n = 16;
    bit win_off = 1'b0;
    int en_cnt = 0;

    logic [15:0] osc_a [RB];
    logic [15:0] osc_b [RB];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // window counter model: valid in the (N+2)th enabled cycle
    always @(negedge clk) begin
        if (bus.o_cnt_en) en_cnt++;
        else en_cnt = 0;
        bus.i_cnt_valid = !win_off && (en_cnt == win_n + 2);
        bus.i_osc_a = osc_a[bus.o_chal];
        bus.i_osc_b = osc_b[bus.o_chal];
    end

    function automatic logic [RB-1:0] exp_resp();
        logic [RB-1:0] r;
        r = '0;
        for (int i = 0; i < RB; i++) begin
            int unsigned a = osc_a[i];
            int unsigned b = osc_b[i];
            r[i] = (a > b);
        end
        return r;
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < RB; i++) begin
            case (mode)
                1: begin
                    osc_a[i] = (i % 2 == 0) ? 16'd300 : 16'd100;
                    osc_b[i] = (i % 2 == 0) ? 16'd299 : 16'd100;
                end
                2: begin
                    osc_a[i] = 16'hFFFF;
                    osc_b[i] = 16'hFFFF;
                end
                3: begin
                    osc_a[i] = 16'hFFFF;
                    osc_b[i] = 16'h0000;
                end
                default: begin
                    osc_a[i] = 16'($urandom);
                    case ($urandom_range(0, 3))
                        0: osc_b[i] = osc_a[i];
                        1: osc_b[i] = osc_a[i] + 16'd1;
                        2: osc_b[i] = osc_a[i] - 16'd1;
                        default: osc_b[i] = 16'($urandom);
                    endcase
                end
            endcase
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
    endtask

    task automatic do_run(input int n, input bit mid_start,
                          input int ack_dly, input bit done_start,
                          input bit ack_start);
        int cyc;
        int chg;
        bit got;
        logic [RB-1:0] er;
        logic [RB-1:0] held;
        win_n = n;
        win_off = 1'b0;
        er = exp_resp();
        pulse_start();
        chk("err_cleared", bus.o_err, 0);
        chk("clear_pulse", {bus.o_osc_clr, bus.o_cnt_en, bus.o_busy}, 3'b101);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < RB * (n + 5) + 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                chk("measure_en", {bus.o_osc_clr, bus.o_cnt_en}, 2'b01);
            end
            bus.i_start = mid_start && (cyc == 1);
            got = bus.o_resp_valid;
        end
        bus.i_start = 1'b0;
        chk("latency", cyc, RB * (1 + (n + 2) + 1 + 1));
        chk("resp", bus.o_resp, er);
        chk("no_err", bus.o_err, 0);
        held = bus.o_resp;
        chg = 0;
        for (int i = 0; i < ack_dly; i++) begin
            bus.i_start = done_start && (i == 0);
            @(posedge clk);
            #1;
            bus.i_start = 1'b0;
            if (!bus.o_resp_valid || bus.o_resp !== held) chg++;
        end
        chk("done_hold", chg, 0);
        @(negedge clk);
        bus.i_resp_ack = 1'b1;
        bus.i_start = ack_start;
        @(posedge clk);
        #1;
        bus.i_resp_ack = 1'b0;
        bus.i_start = 1'b0;
        chk("valid_fall", bus.o_resp_valid, 0);
        chk("idle_after_ack", bus.o_busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("resp_in_idle", {bus.o_busy, bus.o_resp}, {1'b0, er});
    endtask

    task automatic do_timeout();
        int cyc;
        int mcyc;
        bit seen_v;
        win_off = 1'b1;
        pulse_start();
        cyc = 0;
        mcyc = 0;
        seen_v = 1'b0;
        while (bus.o_busy && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.o_cnt_en) mcyc++;
            if (bus.o_resp_valid) seen_v = 1'b1;
        end
        chk("to_measure_cycles", mcyc, TMO);
        chk("to_exit_cycle", cyc, TMO + 1);
        chk("to_err", bus.o_err, 1);
        chk("to_no_valid", seen_v, 0);
        win_off = 1'b0;
    endtask

    task automatic do_mid_reset();
        int cyc;
        fill(3);
        win_n = 16;
        pulse_start();
        cyc = 0;
        while (!(bus.o_chal == 3'd3 && bus.o_cnt_en) && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("reach_chal3", {bus.o_chal, bus.o_cnt_en}, {3'd3, 1'b1});
        repeat (5) @(posedge clk);
        #3;
        chk("resp_partial", bus.o_resp, 8'h07);
        rst_n = 1'b0;
        #1;
        chk("rst_async",
            {bus.o_cnt_en, bus.o_osc_clr, bus.o_chal, bus.o_resp,
             bus.o_resp_valid, bus.o_busy, bus.o_err}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_resp_ack = 1'b0;
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        chk("in_reset",
            {bus.o_cnt_en, bus.o_osc_clr, bus.o_chal, bus.o_resp,
             bus.o_resp_valid, bus.o_busy, bus.o_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            chk("idle_quiet",
                {bus.o_cnt_en, bus.o_osc_clr, bus.o_chal, bus.o_resp,
                 bus.o_resp_valid, bus.o_busy, bus.o_err}, 0);
        end

        fill(1);
        chk("ref_nominal", exp_resp(), 8'h55);
        do_run(16, 1'b1, 100, 1'b1, 1'b0);

        fill(2);
        do_run(16, 1'b0, 2, 1'b0, 1'b1);
        fill(3);
        do_run(16, 1'b0, 0, 1'b0, 1'b0);

        do_timeout();
        fill(0);
        do_run(4, 1'b0, 1, 1'b0, 1'b0);

        fill(0);
        do_run(TMO - 2, 1'b0, 1, 1'b0, 1'b0);

        do_mid_reset();
        fill(0);
        do_run(16, 1'b0, 1, 1'b0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            fill(0);
            do_run(int'($urandom_range(0, 20)), 1'($urandom),
                   int'($urandom_range(0, 5)), 1'($urandom),
                   1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
